// File: rtl/mem_copy_dma.sv
// mem_copy_dma: memory-to-memory copy engine that acts as a second initiator
// on the memory read/write port pair. Each transfer is one READ cycle followed
// by one WRITE cycle. A transfer moves a 32-bit word when both pointers are
// word-aligned and at least four bytes remain; otherwise it moves one byte.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start             begin a copy (only honoured while idle)
//   src_addr/dst_addr source/destination byte addresses, latched on start
//   length            byte count, latched on start
//   busy              high while a copy is in progress (including DONE)
//   done              one-cycle completion pulse
//   read_address      memory read address
//   read_data         memory read data (already extended per funct3)
//   write_mem         memory write enable
//   write_address     memory write address
//   write_data        memory write data
//   funct3            access size/sign shared by the read and write ports
module mem_copy_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic [31:0]      read_address,
  input  logic [31:0]      read_data,
  output logic             write_mem,
  output logic [31:0]      write_address,
  output logic [31:0]      write_data,
  output logic [2:0]       funct3
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] F3_WORD = 3'b010;  // lw / sw
  localparam logic [2:0] F3_LBU  = 3'b100;  // zero-extended byte load
  localparam logic [2:0] F3_SB   = 3'b000;  // byte store

  state_t           state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] remaining;
  logic             word_mode;

  // Word transfers need both pointers aligned and a full word left to move.
  function automatic logic pick_word(input logic [31:0]      s,
                                     input logic [31:0]      d,
                                     input logic [LEN_W-1:0] r);
    return (s[1:0] == 2'b00) && (d[1:0] == 2'b00) && (r >= LEN_W'(4));
  endfunction

  // Pointer/counter values after the transfer currently in WRITE.
  logic [31:0]      src_next;
  logic [31:0]      dst_next;
  logic [LEN_W-1:0] rem_next;
  logic             start_word;
  logic             next_word;

  always_comb begin
    src_next   = src_ptr + (word_mode ? 32'd4 : 32'd1);
    dst_next   = dst_ptr + (word_mode ? 32'd4 : 32'd1);
    rem_next   = remaining - (word_mode ? LEN_W'(4) : LEN_W'(1));
    start_word = pick_word(src_addr, dst_addr, length);
    next_word  = pick_word(src_next, dst_next, rem_next);
  end

  // NOTE: every register, including the data path (pointers, write_data),
  // is reset so an aborted copy leaves no stale address or data on the bus.
  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // see pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      write_mem     <= 1'b0;
      read_address  <= 32'd0;
      write_address <= 32'd0;
      write_data    <= 32'd0;
      funct3        <= F3_WORD;
      src_ptr       <= 32'd0;
      dst_ptr       <= 32'd0;
      remaining     <= '0;
      word_mode     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= length;
            busy      <= 1'b1;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state        <= READ;
              word_mode    <= start_word;
              read_address <= src_addr;
              funct3       <= start_word ? F3_WORD : F3_LBU;
            end
          end
        end

        READ: begin
          // read_data is valid for the address presented this cycle; it
          // becomes the write buffer for the following WRITE.
          write_data    <= read_data;
          write_address <= dst_ptr;
          write_mem     <= 1'b1;
          funct3        <= word_mode ? F3_WORD : F3_SB;
          state         <= WRITE;
        end

        WRITE: begin
          write_mem <= 1'b0;
          src_ptr   <= src_next;
          dst_ptr   <= dst_next;
          remaining <= rem_next;
          if (rem_next == '0) begin
            state  <= DONE;
            done   <= 1'b1;
            funct3 <= F3_WORD;
          end else begin
            state        <= READ;
            word_mode    <= next_word;
            read_address <= src_next;
            funct3       <= next_word ? F3_WORD : F3_LBU;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          funct3 <= F3_WORD;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Testbench for mem_copy_dma: a byte-addressed memory model answers the DUT's
// read/write ports, and a reference model derives the expected transfer list
// and final memory image from the copy rules with plain arithmetic.
module tb_mem_copy_dma;

  localparam int LEN_W    = 16;
  localparam int MEM_SIZE = 4096;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] length;
  logic             busy;
  logic             done;
  logic [31:0]      read_address;
  logic [31:0]      read_data;
  logic             write_mem;
  logic [31:0]      write_address;
  logic [31:0]      write_data;
  logic [2:0]       funct3;

  int passed = 0;
  int total  = 0;

  mem_copy_dma #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .read_address (read_address),
    .read_data    (read_data),
    .write_mem    (write_mem),
    .write_address(write_address),
    .write_data   (write_data),
    .funct3       (funct3)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem     [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];

  function automatic logic [7:0] mem_get(input logic [31:0] a);
    return (a < 32'(MEM_SIZE)) ? mem[a[11:0]] : 8'h00;
  endfunction

  task automatic mem_put(input logic [31:0] a, input logic [7:0] v);
    if (a < 32'(MEM_SIZE)) mem[a[11:0]] = v;
  endtask

  function automatic logic [7:0] ref_get(input logic [31:0] a);
    return (a < 32'(MEM_SIZE)) ? ref_mem[a[11:0]] : 8'h00;
  endfunction

  task automatic ref_put(input logic [31:0] a, input logic [7:0] v);
    if (a < 32'(MEM_SIZE)) ref_mem[a[11:0]] = v;
  endtask

  // Read address sampled at negedge; data ready before the next posedge.
  always @(negedge clk) begin
    if (funct3 == 3'b100)
      read_data = {24'h0, mem_get(read_address)};
    else
      read_data = {mem_get(read_address + 32'd3), mem_get(read_address + 32'd2),
                   mem_get(read_address + 32'd1), mem_get(read_address)};
  end

  // Writes commit at posedge.
  always @(posedge clk) begin
    if (write_mem) begin
      if (funct3 == 3'b010) begin
        for (int i = 0; i < 4; i++) mem_put(write_address + 32'(i), write_data[8*i +: 8]);
      end else if (funct3 == 3'b000) begin
        mem_put(write_address, write_data[7:0]);
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
    ref_mem = mem;
  endtask

  // ---------------- bus monitor ----------------
  logic [31:0] rd_addr_q[$];
  logic [2:0]  rd_f3_q[$];
  logic [31:0] wr_addr_q[$];
  logic [2:0]  wr_f3_q[$];
  int done_cnt, busy_cnt, wm_cnt;

  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (write_mem) begin
        wm_cnt++;
        wr_addr_q.push_back(write_address);
        wr_f3_q.push_back(funct3);
      end else if (busy && !done) begin
        rd_addr_q.push_back(read_address);
        rd_f3_q.push_back(funct3);
      end
    end
  end

  task automatic clear_monitor();
    rd_addr_q.delete(); rd_f3_q.delete();
    wr_addr_q.delete(); wr_f3_q.delete();
    done_cnt = 0; busy_cnt = 0; wm_cnt = 0;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_rd_addr[$];
  logic [2:0]  exp_rd_f3[$];
  logic [31:0] exp_wr_addr[$];
  logic [2:0]  exp_wr_f3[$];

  // Memory effect is a plain forward byte copy; the transfer list follows
  // the alignment/remaining rule. Returns the number of transfers.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d,
                            input int l, output int k);
    int rem;
    int n;
    exp_rd_addr.delete(); exp_rd_f3.delete();
    exp_wr_addr.delete(); exp_wr_f3.delete();
    for (int i = 0; i < l; i++) ref_put(d + 32'(i), ref_get(s + 32'(i)));
    rem = l;
    k   = 0;
    while (rem > 0) begin
      n = (s % 4 == 0 && d % 4 == 0 && rem >= 4) ? 4 : 1;
      exp_rd_addr.push_back(s);
      exp_rd_f3.push_back(n == 4 ? 3'b010 : 3'b100);
      exp_wr_addr.push_back(d);
      exp_wr_f3.push_back(n == 4 ? 3'b010 : 3'b000);
      s   = s + 32'(n);
      d   = d + 32'(n);
      rem = rem - n;
      k++;
    end
  endtask

  function automatic int transfer_mismatches();
    int m = 0;
    if (rd_addr_q.size() != exp_rd_addr.size() || wr_addr_q.size() != exp_wr_addr.size())
      return 1000;
    foreach (exp_rd_addr[i]) begin
      if (rd_addr_q[i] !== exp_rd_addr[i] || rd_f3_q[i] !== exp_rd_f3[i]) m++;
      if (wr_addr_q[i] !== exp_wr_addr[i] || wr_f3_q[i] !== exp_wr_f3[i]) m++;
    end
    return m;
  endfunction

  function automatic int mem_mismatches();
    int m = 0;
    for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) m++;
    return m;
  endfunction

  // Starts a copy and measures cycles from the start posedge to the done
  // pulse (start cycle counts as 1). Returns -1 if done never arrives.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input int l, output int cycles);
    int cyc = 0;
    clear_monitor();
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; length = LEN_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk); cyc++; #1;
    end
    cycles = done ? cyc + 1 : -1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({busy, done, write_mem} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {busy, done, write_mem}); else passed++;
    total++; if (funct3 !== 3'b010) $display("FAIL reset_funct3 got %b want 010", funct3); else passed++;
    total++; if ({read_address, write_address, write_data} !== 96'd0)
      $display("FAIL reset_bus got %h/%h/%h want 0", read_address, write_address, write_data); else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++; if ({busy, done, write_mem} !== 3'b000) $display("FAIL idle_ctrl got %b want 000", {busy, done, write_mem}); else passed++;
  endtask

  task automatic test_word_copy();
    int k, cyc, bad;
    fill_random();
    {mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]} = 32'h11223344;
    {mem[16'h107], mem[16'h106], mem[16'h105], mem[16'h104]} = 32'h55667788;
    ref_mem = mem;
    model_copy(32'h100, 32'h200, 8, k);
    run_copy(32'h100, 32'h200, 8, cyc);
    total++; if (cyc !== 5) $display("FAIL word_cycles got %0d want 5", cyc); else passed++;
    total++; if (transfer_mismatches() !== 0) $display("FAIL word_transfers got %0d bad want 0", transfer_mismatches()); else passed++;
    total++; if ({mem[16'h207], mem[16'h206], mem[16'h205], mem[16'h204], mem[16'h203], mem[16'h202], mem[16'h201], mem[16'h200]} !== 64'h5566778811223344)
      $display("FAIL word_data got %h%h want 5566778811223344",
               {mem[16'h207], mem[16'h206], mem[16'h205], mem[16'h204]}, {mem[16'h203], mem[16'h202], mem[16'h201], mem[16'h200]});
    else passed++;
    bad = 0;
    foreach (rd_f3_q[i]) if (rd_f3_q[i] !== 3'b010) bad++;
    foreach (wr_f3_q[i]) if (wr_f3_q[i] !== 3'b010) bad++;
    total++; if (bad !== 0) $display("FAIL word_funct3 got %0d non-010 samples want 0", bad); else passed++;
    total++; if (mem_mismatches() !== 0) $display("FAIL word_mem got %0d bad bytes want 0", mem_mismatches()); else passed++;
  endtask

  task automatic test_byte_copy();
    int k, cyc;
    logic [7:0] b200, b206;
    fill_random();
    b200 = mem[16'h200];
    b206 = mem[16'h206];
    model_copy(32'h101, 32'h201, 5, k);
    run_copy(32'h101, 32'h201, 5, cyc);
    total++; if (cyc !== 11) $display("FAIL byte_cycles got %0d want 11", cyc); else passed++;
    total++; if (transfer_mismatches() !== 0) $display("FAIL byte_transfers got %0d bad want 0", transfer_mismatches()); else passed++;
    total++; if (mem_mismatches() !== 0) $display("FAIL byte_mem got %0d bad bytes want 0", mem_mismatches()); else passed++;
    total++; if ({mem[16'h200], mem[16'h206]} !== {b200, b206})
      $display("FAIL byte_edges got %h %h want %h %h", mem[16'h200], mem[16'h206], b200, b206); else passed++;
  endtask

  task automatic test_mixed_copy();
    int k, cyc;
    fill_random();
    model_copy(32'h103, 32'h203, 6, k);
    run_copy(32'h103, 32'h203, 6, cyc);
    total++; if (cyc !== 7) $display("FAIL mixed_cycles got %0d want 7", cyc); else passed++;
    total++; if (rd_addr_q.size() !== 3) $display("FAIL mixed_count got %0d want 3", rd_addr_q.size());
    else if ({rd_addr_q[0], rd_addr_q[1], rd_addr_q[2]} !== {32'h103, 32'h104, 32'h108} ||
             {rd_f3_q[0], rd_f3_q[1], rd_f3_q[2]} !== {3'b100, 3'b010, 3'b100})
      $display("FAIL mixed_sizes got %h/%b %h/%b %h/%b want 103/100 104/010 108/100",
               rd_addr_q[0], rd_f3_q[0], rd_addr_q[1], rd_f3_q[1], rd_addr_q[2], rd_f3_q[2]);
    else passed++;
    total++; if (transfer_mismatches() !== 0) $display("FAIL mixed_transfers got %0d bad want 0", transfer_mismatches()); else passed++;
    total++; if (mem_mismatches() !== 0) $display("FAIL mixed_mem got %0d bad bytes want 0", mem_mismatches()); else passed++;
  endtask

  task automatic test_zero_length();
    int k, cyc;
    fill_random();
    model_copy(32'h100, 32'h200, 0, k);
    run_copy(32'h100, 32'h200, 0, cyc);
    total++; if (cyc !== 1) $display("FAIL zero_cycles got %0d want 1", cyc); else passed++;
    total++; if (wm_cnt !== 0) $display("FAIL zero_writes got %0d want 0", wm_cnt); else passed++;
    total++; if (busy_cnt !== 1) $display("FAIL zero_busy got %0d cycles want 1", busy_cnt); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL zero_done got %0d pulses want 1", done_cnt); else passed++;
  endtask

  task automatic test_start_while_busy();
    int k, cyc;
    fill_random();
    model_copy(32'h100, 32'h200, 8, k);
    fork
      run_copy(32'h100, 32'h200, 8, cyc);
      begin
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (write_mem) break;
        end
        #1;
        start = 1'b1; src_addr = 32'h300; dst_addr = 32'h380; length = LEN_W'(4);
        @(negedge clk); #1;
        start = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    total++; if (cyc !== 5) $display("FAIL busy_start_cycles got %0d want 5", cyc); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL busy_start_done got %0d pulses want 1", done_cnt); else passed++;
    total++; if (transfer_mismatches() !== 0) $display("FAIL busy_start_transfers got %0d bad want 0", transfer_mismatches()); else passed++;
    total++; if (busy !== 1'b0 || wm_cnt !== 2) $display("FAIL busy_start_idle got busy=%b writes=%0d want 0/2", busy, wm_cnt); else passed++;
    total++; if (mem_mismatches() !== 0) $display("FAIL busy_start_mem got %0d bad bytes want 0", mem_mismatches()); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int k, cyc, seen;
    fill_random();
    // Only the first word reaches memory before the abort.
    for (int i = 0; i < 4; i++) ref_mem[16'h200 + i] = ref_mem[16'h100 + i];
    clear_monitor();
    @(negedge clk);
    start = 1'b1; src_addr = 32'h100; dst_addr = 32'h200; length = LEN_W'(8);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      if (write_mem) seen++;
      if (seen < 2) @(negedge clk);
    end
    total++; if (seen !== 2) $display("FAIL rst_mid_reach got %0d writes want 2", seen); else passed++;
    #1 reset = 1'b1;
    #1;
    total++; if ({write_mem, busy, done} !== 3'b000) $display("FAIL rst_mid_ctrl got %b want 000", {write_mem, busy, done}); else passed++;
    total++; if (funct3 !== 3'b010) $display("FAIL rst_mid_funct3 got %b want 010", funct3); else passed++;
    @(negedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (done_cnt !== 0) $display("FAIL rst_mid_done got %0d pulses want 0", done_cnt); else passed++;
    total++; if (mem_mismatches() !== 0) $display("FAIL rst_mid_mem got %0d bad bytes want 0", mem_mismatches()); else passed++;
    model_copy(32'h140, 32'h240, 8, k);
    run_copy(32'h140, 32'h240, 8, cyc);
    total++; if (cyc !== 5) $display("FAIL rst_after_cycles got %0d want 5", cyc); else passed++;
    total++; if (mem_mismatches() !== 0) $display("FAIL rst_after_mem got %0d bad bytes want 0", mem_mismatches()); else passed++;
  endtask

  task automatic test_boundaries();
    int k, cyc;
    fill_random();
    // Source wraps from the top of the address space back to 0.
    model_copy(32'hFFFF_FFFE, 32'h600, 4, k);
    run_copy(32'hFFFF_FFFE, 32'h600, 4, cyc);
    total++; if (cyc !== 2 * k + 1) $display("FAIL wrap_cycles got %0d want %0d", cyc, 2 * k + 1); else passed++;
    total++; if (transfer_mismatches() !== 0) $display("FAIL wrap_transfers got %0d bad want 0", transfer_mismatches()); else passed++;
    total++; if (mem_mismatches() !== 0) $display("FAIL wrap_mem got %0d bad bytes want 0", mem_mismatches()); else passed++;
    // Destination runs past the end of physical memory; those writes drop.
    model_copy(32'h700, 32'hFF8, 16, k);
    run_copy(32'h700, 32'hFF8, 16, cyc);
    total++; if (cyc !== 2 * k + 1) $display("FAIL edge_cycles got %0d want %0d", cyc, 2 * k + 1); else passed++;
    total++; if (mem_mismatches() !== 0) $display("FAIL edge_mem got %0d bad bytes want 0", mem_mismatches()); else passed++;
  endtask

  task automatic test_random();
    int k, cyc, l;
    logic [31:0] s, d;
    for (int it = 0; it < 8; it++) begin
      fill_random();
      s = 32'h400 + 32'($urandom_range(0, 255));
      d = 32'h800 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        s[1:0] = 2'b00;
        d[1:0] = 2'b00;
      end
      l = $urandom_range(0, 24);
      model_copy(s, d, l, k);
      run_copy(s, d, l, cyc);
      total++; if (cyc !== 2 * k + 1) $display("FAIL rand%0d_cycles got %0d want %0d", it, cyc, 2 * k + 1); else passed++;
      total++; if (transfer_mismatches() !== 0) $display("FAIL rand%0d_transfers got %0d bad want 0", it, transfer_mismatches()); else passed++;
      total++; if (mem_mismatches() !== 0) $display("FAIL rand%0d_mem got %0d bad bytes want 0", it, mem_mismatches()); else passed++;
    end
  endtask

  initial begin
    clear_monitor();
    test_reset();
    test_word_copy();
    test_byte_copy();
    test_mixed_copy();
    test_zero_length();
    test_start_while_busy();
    test_reset_mid_op();
    test_boundaries();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
